full_connect_seq: RTL



---
 rtl/fc_pkg.sv | 42 ++++
 rtl/fc_lane_mask.sv | 15 +
 rtl/full_connect_seq.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fc_pkg.sv
// Shared types and arithmetic helpers for the fully-connected layer sequencer.
package fc_pkg;

  typedef enum logic [2:0] {IDLE, RD, OP, AC, POST, WR, FIN} fc_state_e;

  localparam int FC_LANES  = 128;
  localparam int FC_DATA_W = 8;
  localparam int FC_PROD_W = 15;

  // Signed add clamped to a w-bit two's complement range; sat reports clamping.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int w,
                                                 output logic sat);
    logic signed [63:0] s, hi, lo;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (w - 1));
    s   = a + b;
    sat = 1'b0;
    if (s > hi) begin
      s   = hi;
      sat = 1'b1;
    end else if (s < lo) begin
      s   = lo;
      sat = 1'b1;
    end
    return s;
  endfunction

  // Arithmetic shift, optional ReLU, then clamp into int8.
  function automatic logic signed [7:0] requant(input logic signed [63:0] acc,
                                                input int sh,
                                                input logic relu);
    logic signed [63:0] r;
    r = acc >>> sh;
    if (relu && r < 0) r = '0;
    if (r > 64'sd127) r = 64'sd127;
    else if (r < -64'sd128) r = -64'sd128;
    return 8'(r);
  endfunction

endpackage

// File: rtl/fc_lane_mask.sv
// Tail mask: lane k is valid when k is below the number of inputs still left.
module fc_lane_mask #(
  parameter int LANES = 128
) (
  input  logic [31:0]      remaining,
  output logic [LANES-1:0] valid
);

  // Thermometer decode of the remaining count.
  always_comb begin
    valid = '0;
    for (int k = 0; k < LANES; k++) valid[k] = (32'(k) < remaining);
  end

endmodule

// File: rtl/full_connect_seq.sv
// Fully-connected layer sequencer: streams weight rows and activations through
// the external MultAdder, accumulates per neuron, requantises to int8 and
// writes packed result words back to RAM.
// Build option: define FC_RELU_EN to clip negative results to 0 before clamping.
module full_connect_seq
  import fc_pkg::*;
#(
  parameter int LANES        = FC_LANES,
  parameter int DATA_W       = FC_DATA_W,
  parameter int PROD_W       = FC_PROD_W,
  parameter int ACC_W        = 24,
  parameter int IN_LEN       = 784,
  parameter int OUT_LEN      = 128,
  parameter int SHIFT        = 7,
  parameter int ROM_BASE     = 0,
  parameter int RAM_IN_BASE  = 0,
  parameter int RAM_OUT_BASE = 64
) (
  input  logic                       clk,
  input  logic                       iRst,
  input  logic                       start,
  input  logic [LANES*DATA_W-1:0]    data_from_rom,
  input  logic [LANES*DATA_W-1:0]    data_from_ram,
  input  logic signed [PROD_W-1:0]   data_from_MultAdder,
  input  logic                       overflow_from_MultAdder,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow,
  output logic [31:0]                addr_to_rom,
  output logic [31:0]                addr_to_ram,
  output logic                       ram_we,
  output logic [LANES*DATA_W-1:0]    opr1_to_MultAdder,
  output logic [LANES*DATA_W-1:0]    opr2_to_MultAdder,
  output logic [LANES*DATA_W-1:0]    data_to_ram
);

  localparam int CHUNKS = (IN_LEN + LANES - 1) / LANES;
  localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int W      = LANES * DATA_W;
`ifdef FC_RELU_EN
  localparam logic RELU = 1'b1;
`else
  localparam logic RELU = 1'b0;
`endif

  fc_state_e                     state, state_n;
  logic [31:0]                   o, c;
  logic signed [ACC_W-1:0]       acc;
  logic [LANES-1:0][DATA_W-1:0]  obuf;
  logic [31:0]                   rom_addr_q, ram_addr_q;
  logic [W-1:0]                  wdata_q, opr2_masked;
  logic [LANES-1:0]              lane_valid;
  logic [31:0]                   remaining;
  logic [LW-1:0]                 lane_idx;
  logic                          last_chunk, last_out, word_full, sat_hit;
  logic signed [63:0]            sum_full;
  logic signed [7:0]             q;

  assign last_chunk = (c == 32'(CHUNKS - 1));
  assign last_out   = (o == 32'(OUT_LEN - 1));
  assign lane_idx   = LW'(o % 32'(LANES));
  assign word_full  = (lane_idx == LW'(LANES - 1));
  assign remaining  = 32'(IN_LEN) - c * 32'(LANES);

  fc_lane_mask #(.LANES(LANES)) u_mask (
    .remaining (remaining),
    .valid     (lane_valid)
  );

  // Zero activation lanes beyond the end of the input vector.
  always_comb begin
    opr2_masked = '0;
    for (int k = 0; k < LANES; k++)
      opr2_masked[k*DATA_W +: DATA_W] = lane_valid[k] ? data_from_ram[k*DATA_W +: DATA_W] : '0;
  end

  // Saturating accumulate and requantisation of the current neuron.
  always_comb begin
    sat_hit  = 1'b0;
    sum_full = sat_add(64'(acc), 64'(data_from_MultAdder), ACC_W, sat_hit);
    q        = requant(64'(acc), SHIFT, RELU);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (iRst) state <= IDLE;
    else      state <= state_n;
  end

  // Next state plus state-decoded outputs; addresses and write data hold between uses.
  always_comb begin
    state_n     = state;
    busy        = 1'b0;
    done        = 1'b0;
    ram_we      = 1'b0;
    addr_to_rom = rom_addr_q;
    addr_to_ram = ram_addr_q;
    data_to_ram = wdata_q;
    case (state)
      IDLE: if (start) state_n = RD;
      RD: begin
        busy        = 1'b1;
        addr_to_rom = 32'(ROM_BASE) + o * 32'(CHUNKS) + c;
        addr_to_ram = 32'(RAM_IN_BASE) + c;
        state_n     = OP;
      end
      OP: begin
        busy    = 1'b1;
        state_n = AC;
      end
      AC: begin
        busy    = 1'b1;
        state_n = last_chunk ? POST : RD;
      end
      POST: begin
        busy    = 1'b1;
        state_n = (word_full || last_out) ? WR : RD;
      end
      WR: begin
        busy        = 1'b1;
        ram_we      = 1'b1;
        addr_to_ram = 32'(RAM_OUT_BASE) + o / 32'(LANES);
        data_to_ram = obuf;
        state_n     = last_out ? FIN : RD;
      end
      FIN: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath: counters, operand registers, accumulator, output buffer, sticky flag.
  always_ff @(posedge clk) begin
    if (iRst) begin
      o                 <= '0;
      c                 <= '0;
      acc               <= '0;
      obuf              <= '0;
      overflow          <= 1'b0;
      opr1_to_MultAdder <= '0;
      opr2_to_MultAdder <= '0;
      rom_addr_q        <= '0;
      ram_addr_q        <= '0;
      wdata_q           <= '0;
    end else begin
      rom_addr_q <= addr_to_rom;
      ram_addr_q <= addr_to_ram;
      wdata_q    <= data_to_ram;
      case (state)
        IDLE: if (start) begin
          o        <= '0;
          c        <= '0;
          acc      <= '0;
          obuf     <= '0;
          overflow <= 1'b0;
        end
        OP: begin
          opr1_to_MultAdder <= data_from_rom;
          opr2_to_MultAdder <= opr2_masked;
        end
        AC: begin
          acc <= ACC_W'(sum_full);
          if (sat_hit || overflow_from_MultAdder) overflow <= 1'b1;
          if (!last_chunk) c <= c + 32'd1;
        end
        POST: begin
          obuf[lane_idx] <= DATA_W'(q);
          acc            <= '0;
          c              <= '0;
          if (!(word_full || last_out)) o <= o + 32'd1;
        end
        WR: begin
          obuf <= '0;
          if (!last_out) o <= o + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
